// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the 4x4 matrix keypad scanner.
//   state_t     - scanner FSM states
//   ROWS/COLS   - keypad geometry
//   KEY_*       - one-hot bit index of each key (row*4 + col), row-major layout
//   col_drive() - active-low column drive pattern for a column index
package keypad_pkg;

    localparam int unsigned ROWS = 4;
    localparam int unsigned COLS = 4;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DEBOUNCE,
        PRESSED
    } state_t;

    localparam int unsigned KEY_1    = 0;
    localparam int unsigned KEY_2    = 1;
    localparam int unsigned KEY_3    = 2;
    localparam int unsigned KEY_A    = 3;
    localparam int unsigned KEY_4    = 4;
    localparam int unsigned KEY_5    = 5;
    localparam int unsigned KEY_6    = 6;
    localparam int unsigned KEY_B    = 7;
    localparam int unsigned KEY_7    = 8;
    localparam int unsigned KEY_8    = 9;
    localparam int unsigned KEY_9    = 10;
    localparam int unsigned KEY_C    = 11;
    localparam int unsigned KEY_STAR = 12;
    localparam int unsigned KEY_0    = 13;
    localparam int unsigned KEY_HASH = 14;
    localparam int unsigned KEY_D    = 15;

    function automatic logic [3:0] col_drive(input logic [1:0] col);
        return ~(4'b0001 << col);
    endfunction

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// sync_2ff: 4-bit two-flop synchronizer for the asynchronous keypad rows.
//   clk   - system clock
//   rst_n - synchronous active-low reset; both stages reset to 4'hF (rows idle high)
//   d     - asynchronous input
//   q     - synchronized output
module sync_2ff (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad, debounces press and
// release, and emits a one-hot key code.
//   clk       - system clock
//   rst_n     - synchronous reset, active-low
//   en        - scan enable; low idles the scanner (col_out = 4'hF)
//   row_in    - keypad rows, active-low, asynchronous
//   col_out   - column drive, active-low, one bit low while scanning
//   key_data  - one-hot code of the last accepted key (bit = row*4+col)
//   key_valid - one-cycle pulse when a new key is accepted
//   key_held  - high while the accepted key remains pressed
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned DEBOUNCE_CNT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [3:0]  row_in,
    output logic [3:0]  col_out,
    output logic [15:0] key_data,
    output logic        key_valid,
    output logic        key_held
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CNT + 1);

    logic [3:0]       row_sync;
    logic [DIV_W-1:0] div_q;
    logic             sample;

    state_t           state_q, state_d;
    logic [1:0]       col_q, col_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       cand_q, cand_d;     // {row, col} of the key being tracked
    logic [15:0]      key_data_d;
    logic             key_valid_d;
    logic             key_held_d;

    logic             one_low;
    logic [1:0]       low_row;

    sync_2ff u_row_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (row_in),
        .q     (row_sync)
    );

    assign sample = (div_q == DIV_W'(SCAN_DIV - 1));

    // Exactly one row low identifies a single key; two or more low rows is
    // ghosting/rollover and is treated as no key.
    always_comb begin
        one_low = ($countones(~row_sync) == 1);
        low_row = '0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            if (!row_sync[r]) begin
                low_row = 2'(r);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        cnt_d       = cnt_q;
        cand_d      = cand_q;
        key_data_d  = key_data;
        key_valid_d = 1'b0;
        key_held_d  = key_held;

        if (sample) begin
            case (state_q)
                SCAN: begin
                    if (one_low) begin
                        cand_d  = {low_row, col_q};
                        cnt_d   = CNT_W'(1);
                        state_d = DEBOUNCE;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end

                DEBOUNCE: begin
                    if (one_low && (low_row == cand_q[3:2])) begin
                        if (cnt_q == CNT_W'(DEBOUNCE_CNT - 1)) begin
                            key_data_d  = 16'(1) << cand_q;
                            key_valid_d = 1'b1;
                            key_held_d  = 1'b1;
                            cnt_d       = '0;
                            state_d     = PRESSED;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = SCAN;
                    end
                end

                PRESSED: begin
                    // Only the accepted key's row matters; other keys in the
                    // held column are ignored until this one is released.
                    if (row_sync[cand_q[3:2]]) begin
                        if (cnt_q == CNT_W'(DEBOUNCE_CNT - 1)) begin
                            key_held_d = 1'b0;
                            cnt_d      = '0;
                            state_d    = SCAN;
                            col_d      = col_q + 2'd1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end

                default: begin
                    cnt_d   = '0;
                    state_d = SCAN;
                end
            endcase
        end
    end

    // col_out is registered from the next column so it always equals the
    // drive pattern of col_q while enabled, and reads 4'hF after reset/idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= SCAN;
            col_q     <= '0;
            div_q     <= '0;
            cnt_q     <= '0;
            cand_q    <= '0;
            col_out   <= '1;
            key_data  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else if (!en) begin
            state_q   <= SCAN;
            col_q     <= '0;
            div_q     <= '0;
            cnt_q     <= '0;
            col_out   <= '1;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            div_q     <= sample ? '0 : div_q + DIV_W'(1);
            cnt_q     <= cnt_d;
            cand_q    <= cand_d;
            col_out   <= col_drive(col_d);
            key_data  <= key_data_d;
            key_valid <= key_valid_d;
            key_held  <= key_held_d;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: randomized and directed stimulus for keypad_scanner,
// checked every cycle against a behavioural keypad-scanner reference model.
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DC = 3;

    localparam int P_SCAN    = 0;
    localparam int P_DEB     = 1;
    localparam int P_PRESSED = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [15:0] key_data;
    logic        key_valid;
    logic        key_held;

    logic [15:0] keys = '0;   // physically pressed keys, bit = row*4+col

    int n_checks = 0;
    int n_pass   = 0;
    int pulses   = 0;

    // reference model state
    int          m_phase, m_col, m_div, m_cnt, m_key;
    logic [3:0]  m_s1, m_s2;
    logic [15:0] m_data;
    bit          m_valid, m_held, m_on;

    always #5 clk = ~clk;

    // Keypad matrix: a pressed key shorts its row to its column when driven low.
    always_comb begin
        row_in = '1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!col_out[c] && keys[r*4+c]) row_in[r] = 1'b0;
    end

    keypad_scanner #(
        .SCAN_DIV     (SD),
        .DEBOUNCE_CNT (DC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_data  (key_data),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    task automatic model_sample(input logic [3:0] seen);
        int n_low = 0;
        int r_low = 0;
        for (int r = 0; r < 4; r++)
            if (!seen[r]) begin n_low++; r_low = r; end
        if (m_phase == P_SCAN) begin
            if (n_low == 1) begin
                m_key = r_low * 4 + m_col;
                m_cnt = 1;
                m_phase = P_DEB;
            end else begin
                m_col = (m_col + 1) % 4;
            end
        end else if (m_phase == P_DEB) begin
            if (n_low == 1 && r_low == m_key / 4) begin
                m_cnt++;
                if (m_cnt == DC) begin
                    m_data = '0;
                    m_data[m_key] = 1'b1;
                    m_valid = 1;
                    m_held = 1;
                    m_cnt = 0;
                    m_phase = P_PRESSED;
                end
            end else begin
                m_cnt = 0;
                m_phase = P_SCAN;
            end
        end else begin
            if (seen[m_key / 4]) begin
                m_cnt++;
                if (m_cnt == DC) begin
                    m_held = 0;
                    m_cnt = 0;
                    m_phase = P_SCAN;
                    m_col = (m_col + 1) % 4;
                end
            end else begin
                m_cnt = 0;
            end
        end
    endtask

    // Advance the model by one clock using the inputs the DUT will see at the edge.
    task automatic model_step();
        logic [3:0] seen;
        seen = m_s2;
        m_s2 = m_s1;
        m_s1 = row_in;
        if (!rst_n) begin
            m_s1 = '1; m_s2 = '1;
            m_phase = P_SCAN; m_col = 0; m_div = 0; m_cnt = 0; m_key = 0;
            m_data = '0; m_valid = 0; m_held = 0; m_on = 0;
        end else if (!en) begin
            m_phase = P_SCAN; m_col = 0; m_div = 0; m_cnt = 0;
            m_valid = 0; m_held = 0; m_on = 0;
        end else begin
            m_valid = 0;
            m_on = 1;
            if (m_div == SD - 1) model_sample(seen);
            m_div = (m_div + 1) % SD;
        end
    endtask

    task automatic tick();
        logic [3:0] exp_col;
        #1;
        model_step();
        @(posedge clk);
        #1;
        exp_col = m_on ? ~(4'b0001 << m_col) : 4'hF;
        check("col_out", {28'd0, col_out}, {28'd0, exp_col});
        check("key_valid", {31'd0, key_valid}, {31'd0, m_valid});
        check("key_held", {31'd0, key_held}, {31'd0, m_held});
        check("key_data", {16'd0, key_data}, {16'd0, m_data});
        if (key_valid === 1'b1) pulses++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_held(input logic v, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (key_held === v) break;
            tick();
        end
        check("wait_held", {31'd0, key_held}, {31'd0, v});
    endtask

    task automatic wait_phase(input int p, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (m_phase == p) break;
            tick();
        end
        check("wait_phase", m_phase, p);
    endtask

    initial begin
        m_s1 = '1; m_s2 = '1;
        rst_n = 1'b0; en = 1'b0;
        run(2);
        check("rst_col", {28'd0, col_out}, 32'hF);
        check("rst_data", {16'd0, key_data}, 32'h0);
        rst_n = 1'b1; en = 1'b1;
        run(3);

        // steady press of '5'
        pulses = 0; keys = 16'h0020;
        wait_held(1'b1, 200);
        run(20);
        check("p5_pulses", pulses, 1);
        check("p5_data", {16'd0, key_data}, 32'h0020);
        keys = '0;
        wait_held(1'b0, 100);
        run(10);
        check("p5_after_data", {16'd0, key_data}, 32'h0020);
        check("p5_after_pulses", pulses, 1);

        // '#' with one released sample after first detection
        pulses = 0; keys = 16'h4000;
        wait_phase(P_DEB, 200);
        keys = '0;
        run(SD);
        check("bounce_pulses", pulses, 0);
        keys = 16'h4000;
        wait_held(1'b1, 200);
        run(5);
        check("hash_pulses", pulses, 1);
        check("hash_data", {16'd0, key_data}, 32'h4000);
        keys = '0;
        wait_held(1'b0, 100);

        // ghosting: '1' and '4' together
        pulses = 0; keys = 16'h0011;
        run(100);
        check("ghost_pulses", pulses, 0);
        check("ghost_held", {31'd0, key_held}, 32'd0);
        keys = '0;
        run(10);

        // hold '0', add 'A', release both, then press 'A'
        pulses = 0; keys = 16'h2000;
        wait_held(1'b1, 200);
        keys = 16'h2008;
        run(60);
        check("hold0_pulses", pulses, 1);
        check("hold0_data", {16'd0, key_data}, 32'h2000);
        keys = '0;
        wait_held(1'b0, 100);
        run(20);
        check("rel_pulses", pulses, 1);
        keys = 16'h0008;
        wait_held(1'b1, 200);
        run(5);
        check("a_pulses", pulses, 2);
        check("a_data", {16'd0, key_data}, 32'h0008);
        keys = '0;
        wait_held(1'b0, 100);

        // en dropped mid-debounce on '9'
        pulses = 0; keys = 16'h0400;
        wait_phase(P_DEB, 200);
        en = 1'b0;
        tick();
        check("en_off_col", {28'd0, col_out}, 32'hF);
        check("en_off_data", {16'd0, key_data}, 32'h0008);
        run(5);
        check("en_off_pulses", pulses, 0);
        en = 1'b1;
        tick();
        check("en_on_col", {28'd0, col_out}, 32'hE);
        wait_held(1'b1, 200);
        check("nine_data", {16'd0, key_data}, 32'h0400);
        check("nine_pulses", pulses, 1);
        keys = '0;
        wait_held(1'b0, 100);

        // reset while pressed
        keys = 16'h0040;
        wait_held(1'b1, 200);
        pulses = 0;
        rst_n = 1'b0;
        tick();
        check("rstp_col", {28'd0, col_out}, 32'hF);
        check("rstp_data", {16'd0, key_data}, 32'h0);
        check("rstp_held", {31'd0, key_held}, 32'd0);
        rst_n = 1'b1;
        wait_held(1'b1, 200);
        run(2);
        check("rstp_pulses", pulses, 1);
        check("rstp_redata", {16'd0, key_data}, 32'h0040);
        keys = '0;
        wait_held(1'b0, 100);

        // randomized episodes
        for (int ep = 0; ep < 150; ep++) begin
            logic [15:0] k;
            k = '0;
            k[$urandom_range(0, 15)] = 1'b1;
            if ($urandom_range(0, 4) == 0) k[$urandom_range(0, 15)] = 1'b1;
            keys = k;
            run($urandom_range(5, 80));
            if ($urandom_range(0, 9) == 0) begin
                en = 1'b0;
                run($urandom_range(1, 6));
                en = 1'b1;
            end
            if ($urandom_range(0, 19) == 0) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end
            run($urandom_range(0, 20));
            keys = '0;
            run($urandom_range(5, 60));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 active-low matrix keypad, debounces presses and emits a one-hot 16-bit key code.
- The code feeds the existing keypad-to-7-segment decoder's data/en inputs, making this the producing end of that 16-bit key interface.
- Sits between the board keypad pins and the lock's display/compare logic.

Parameters:
- SCAN_DIV, 1000: clock cycles each column is driven; minimum 4.
- DEBOUNCE_CNT, 8: consecutive identical samples required to accept a press or a release; minimum 2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous reset, active-low.
- en  input  1  scan enable; low idles the scanner.
- row_in  input  4  keypad rows, active-low, externally pulled up, asynchronous.
- col_out  output  4  column drive, active-low, exactly one bit low while scanning.
- key_data  output  16  one-hot code of the last accepted key; bit = row*4+col.
- key_valid  output  1  one-cycle pulse when a new key is accepted.
- key_held  output  1  high while the accepted key remains pressed.

Behaviour:
- Reset (rst_n low at a clk edge): col_out=4'hF, key_data=16'h0000, key_valid=0, key_held=0, state=SCAN, column index=0, divider=0, debounce count=0. A reset mid-press discards all progress.
- row_in passes through a 2-flop synchronizer; all decisions use the synchronized value.
- Divider counts 0..SCAN_DIV-1 and wraps. A "sample" occurs when the divider equals SCAN_DIV-1.
- col_out drives column index c low (col_out = ~(1<<c)) in every state except the idle state.
- Key layout, row-major: row0 = 1 2 3 A, row1 = 4 5 6 B, row2 = 7 8 9 C, row3 = * 0 # D.
- SCAN state:
  - At each sample, if all rows are high, advance the column (3 wraps to 0).
  - If exactly one row r is low: latch cand={r,c}, set count=1, hold the column, go to DEBOUNCE.
  - If two or more rows are low (ghosting/rollover), treat it as no key and advance the column.
- DEBOUNCE state:
  - At each sample, if only row r is low, increment count.
  - When count reaches DEBOUNCE_CNT: in the same cycle register key_data=1<<cand; key_valid goes high for the next cycle only; key_held=1; count=0; go to PRESSED.
  - Any other row pattern: clear count and return to SCAN, with no output change.
- PRESSED state:
  - The column stays fixed.
  - At each sample, if row r is high, increment count; otherwise clear count.
  - When count reaches DEBOUNCE_CNT: key_held=0, go to SCAN, advance the column.
  - Pressing a second key while holding produces no output.
- key_data holds the last accepted key until the next acceptance or reset; it is never cleared on release.
- key_valid is never high for two consecutive cycles.
- en low (sampled each cycle), overriding every state except reset:
  - next cycle: state=SCAN, col_out=4'hF, divider/count/column=0, key_held=0, key_valid=0; key_data retained.
  - en returning high: scanning restarts at column 0 with the divider at 0.
- Latency, from a row stable low in a driven column until key_valid: at most 2 sync cycles + (DEBOUNCE_CNT+4)*SCAN_DIV cycles.

Decomposition:
- keypad_pkg holds:
  - state enum {IDLE, SCAN, DEBOUNCE, PRESSED};
  - KEY_* index constants (KEY_1=0 ... KEY_D=15, KEY_STAR=12, KEY_0=13, KEY_HASH=14);
  - the ROWS/COLS=4 constants.
- One sub-module, sync_2ff (4-bit two-flop synchronizer with reset to 4'hF), instantiated for row_in.
- Divider, FSM and outputs stay in keypad_scanner.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=3; keypad model pulls row r low when col_out[c]=0 and key (r,c) is pressed):
- Press '5' (row1,col1) steadily -> exactly one key_valid pulse; key_data=16'h0020; key_held=1 until 3 released samples, then 0; key_data still 16'h0020 afterwards.
- Press '#' (row3,col2) with a bounce (released for 1 sample after the first detection), then stable -> no pulse during the bounce; a single pulse afterwards with key_data=16'h4000.
- Press '1' and '4' simultaneously (rows 0 and 1 low in col0) -> no key_valid; col_out keeps cycling E,D,B,7.
- Hold '0' (row3,col1), then add 'A' (row0,col3) while held -> one pulse with key_data=16'h2000; no second pulse until both keys are released and 'A' is pressed again -> 16'h0008.
- Drop en mid-DEBOUNCE on key '9' -> col_out=4'hF the next cycle; no pulse; key_data unchanged. Raise en with '9' still held -> scan restarts at col_out=4'hE, and after debounce key_data=16'h0400.
- Apply rst_n=0 for one cycle while in PRESSED -> all outputs return to their reset values at the next edge; the still-held key is re-detected as a new press with a fresh key_valid pulse.
